// File: rtl/wb2native_pkg.sv
// Shared types and encodings for the Wishbone-to-native burst bridge.
package wb2native_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WDATA,
    RDATA,
    ACK,
    ERR
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

endpackage

// File: rtl/wb_burst_addr_gen.sv
// Combinational burst address advance and address-window check.
module wb_burst_addr_gen
  import wb2native_pkg::*;
#(
  parameter int                  WB_ADR_W  = 32,
  parameter logic [WB_ADR_W-1:0] BASE_ADDR = 32'h40000000,
  parameter logic [WB_ADR_W-1:0] ADDR_SPAN = 32'h10000000
) (
  input  logic [WB_ADR_W-1:0] addr,
  input  logic [1:0]          bte,
  output logic [WB_ADR_W-1:0] next_addr,
  output logic [WB_ADR_W-1:0] offset,
  output logic                in_window
);

  localparam logic [WB_ADR_W-1:0] ADR_ONE = 1;

  logic [WB_ADR_W:0] diff;

  // The extra borrow bit flags addresses below the window base.
  always_comb begin
    diff      = {1'b0, addr} - {1'b0, BASE_ADDR};
    offset    = diff[WB_ADR_W-1:0];
    in_window = !diff[WB_ADR_W] && (offset < ADDR_SPAN);
  end

  always_comb begin
    next_addr = addr + ADR_ONE;
    case (bte)
      BTE_LINEAR: next_addr = addr + ADR_ONE;
      BTE_WRAP4:  next_addr = {addr[WB_ADR_W-1:2], addr[1:0] + 2'd1};
      BTE_WRAP8:  next_addr = {addr[WB_ADR_W-1:3], addr[2:0] + 3'd1};
      BTE_WRAP16: next_addr = {addr[WB_ADR_W-1:4], addr[3:0] + 4'd1};
      default:    next_addr = addr + ADR_ONE;
    endcase
  end

endmodule

// File: rtl/wb2native_burst.sv
// Wishbone B4 slave to native user-port bridge with windowed addressing,
// registered-feedback bursts, native first/last framing and a burst cap.
module wb2native_burst
  import wb2native_pkg::*;
#(
  parameter int                  DATA_W    = 256,
  parameter int                  WB_ADR_W  = 32,
  parameter int                  NAT_ADR_W = 32,
  parameter logic [WB_ADR_W-1:0] BASE_ADDR = 32'h40000000,
  parameter logic [WB_ADR_W-1:0] ADDR_SPAN = 32'h10000000,
  parameter int                  MAX_BURST = 16,
  localparam int                 SEL_W     = DATA_W / 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [WB_ADR_W-1:0]  wishbone_port_adr,
  input  logic [DATA_W-1:0]    wishbone_port_dat_w,
  output logic [DATA_W-1:0]    wishbone_port_dat_r,
  input  logic [SEL_W-1:0]     wishbone_port_sel,
  input  logic                 wishbone_port_cyc,
  input  logic                 wishbone_port_stb,
  input  logic                 wishbone_port_we,
  input  logic [2:0]           wishbone_port_cti,
  input  logic [1:0]           wishbone_port_bte,
  output logic                 wishbone_port_ack,
  output logic                 wishbone_port_err,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic                 cmd_first,
  output logic                 cmd_last,
  output logic                 cmd_payload_we,
  output logic [NAT_ADR_W-1:0] cmd_payload_addr,
  output logic                 wdata_valid,
  input  logic                 wdata_ready,
  output logic                 wdata_first,
  output logic                 wdata_last,
  output logic [DATA_W-1:0]    wdata_payload_data,
  output logic [SEL_W-1:0]     wdata_payload_we,
  input  logic                 rdata_valid,
  output logic                 rdata_ready,
  input  logic                 rdata_first,
  input  logic                 rdata_last,
  input  logic [DATA_W-1:0]    rdata_payload_data
);

  localparam int              CNT_W   = $clog2(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t               state, state_n;
  logic                 in_burst;
  logic [CNT_W-1:0]     beat_cnt;
  logic [WB_ADR_W-1:0]  next_addr;
  logic [WB_ADR_W-1:0]  pend_addr;
  logic [NAT_ADR_W-1:0] lat_addr;
  logic                 lat_we;
  logic [SEL_W-1:0]     lat_sel;
  logic [DATA_W-1:0]    lat_dat;
  logic                 lat_first;
  logic                 lat_last;
  logic                 lat_cap;
  logic                 aborted;
  logic [DATA_W-1:0]    dat_r;

  logic [WB_ADR_W-1:0]  eff_addr;
  logic [WB_ADR_W-1:0]  adv_addr;
  logic [WB_ADR_W-1:0]  win_offset;
  logic                 in_window;
  logic                 start;
  logic                 is_incr;
  logic                 cap_hit;
  logic                 unused_rdata_frame;

  assign unused_rdata_frame = rdata_first ^ rdata_last;

  assign eff_addr = in_burst ? next_addr : wishbone_port_adr;
  assign start    = wishbone_port_cyc && wishbone_port_stb;
  assign is_incr  = (wishbone_port_cti == CTI_INCR);
  assign cap_hit  = (beat_cnt == CNT_CAP);

  wb_burst_addr_gen #(
    .WB_ADR_W (WB_ADR_W),
    .BASE_ADDR(BASE_ADDR),
    .ADDR_SPAN(ADDR_SPAN)
  ) u_addr_gen (
    .addr     (eff_addr),
    .bte      (wishbone_port_bte),
    .next_addr(adv_addr),
    .offset   (win_offset),
    .in_window(in_window)
  );

  // An aborted beat still finishes its native handshake but skips ACK.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = in_window ? CMD : ERR;
      CMD:     if (cmd_ready) state_n = lat_we ? WDATA : RDATA;
      WDATA:   if (wdata_ready) state_n = (aborted || !wishbone_port_cyc) ? IDLE : ACK;
      RDATA:   if (rdata_valid) state_n = (aborted || !wishbone_port_cyc) ? IDLE : ACK;
      ACK:     state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      in_burst  <= 1'b0;
      beat_cnt  <= '0;
      next_addr <= '0;
      pend_addr <= '0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_sel   <= '0;
      lat_dat   <= '0;
      lat_first <= 1'b0;
      lat_last  <= 1'b0;
      lat_cap   <= 1'b0;
      aborted   <= 1'b0;
      dat_r     <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (start && in_window) begin
            lat_addr  <= NAT_ADR_W'(win_offset);
            lat_we    <= wishbone_port_we;
            lat_sel   <= wishbone_port_sel;
            lat_dat   <= wishbone_port_dat_w;
            lat_first <= (beat_cnt == '0);
            lat_last  <= !is_incr || cap_hit;
            lat_cap   <= is_incr && cap_hit;
            pend_addr <= adv_addr;
            aborted   <= 1'b0;
          end
        end
        RDATA: if (rdata_valid) dat_r <= rdata_payload_data;
        ACK: begin
          // A capped beat ends the native burst but keeps the Wishbone address stream.
          if (lat_last && !lat_cap) begin
            in_burst <= 1'b0;
            beat_cnt <= '0;
          end else begin
            in_burst  <= 1'b1;
            beat_cnt  <= lat_cap ? '0 : beat_cnt + CNT_ONE;
            next_addr <= pend_addr;
          end
        end
        ERR: begin
          in_burst <= 1'b0;
          beat_cnt <= '0;
        end
        default: ;
      endcase
      if (!wishbone_port_cyc) begin
        in_burst <= 1'b0;
        beat_cnt <= '0;
        if (state == CMD || state == WDATA || state == RDATA) aborted <= 1'b1;
      end
    end
  end

  assign wishbone_port_ack   = (state == ACK);
  assign wishbone_port_err   = (state == ERR);
  assign wishbone_port_dat_r = dat_r;
  assign cmd_valid           = (state == CMD);
  assign cmd_first           = lat_first;
  assign cmd_last            = lat_last;
  assign cmd_payload_we      = lat_we;
  assign cmd_payload_addr    = lat_addr;
  assign wdata_valid         = (state == WDATA);
  assign wdata_first         = lat_first;
  assign wdata_last          = lat_last;
  assign wdata_payload_data  = lat_dat;
  assign wdata_payload_we    = lat_sel;
  assign rdata_ready         = (state == RDATA);

endmodule

// File: tb/tb_wb2native_burst.sv
// Directed bench for wb2native_burst: table-driven single beats plus burst,
// cap, abort and reset sequences, checked against hand-computed values.
module tb_wb2native_burst;
  import wb2native_pkg::*;

  localparam int DATA_W    = 64;
  localparam int SEL_W     = DATA_W / 8;
  localparam int MAX_BURST = 4;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic [31:0]       wishbone_port_adr = '0;
  logic [DATA_W-1:0] wishbone_port_dat_w = '0;
  logic [DATA_W-1:0] wishbone_port_dat_r;
  logic [SEL_W-1:0]  wishbone_port_sel = '0;
  logic              wishbone_port_cyc = 1'b0;
  logic              wishbone_port_stb = 1'b0;
  logic              wishbone_port_we = 1'b0;
  logic [2:0]        wishbone_port_cti = '0;
  logic [1:0]        wishbone_port_bte = '0;
  logic              wishbone_port_ack;
  logic              wishbone_port_err;
  logic              cmd_valid;
  logic              cmd_ready = 1'b1;
  logic              cmd_first;
  logic              cmd_last;
  logic              cmd_payload_we;
  logic [31:0]       cmd_payload_addr;
  logic              wdata_valid;
  logic              wdata_ready = 1'b1;
  logic              wdata_first;
  logic              wdata_last;
  logic [DATA_W-1:0] wdata_payload_data;
  logic [SEL_W-1:0]  wdata_payload_we;
  logic              rdata_valid = 1'b0;
  logic              rdata_ready;
  logic              rdata_first = 1'b0;
  logic              rdata_last = 1'b0;
  logic [DATA_W-1:0] rdata_payload_data = '0;

  always #5 sys_clk = ~sys_clk;

  wb2native_burst #(
    .DATA_W   (DATA_W),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .sys_clk            (sys_clk),
    .sys_rst            (sys_rst),
    .wishbone_port_adr  (wishbone_port_adr),
    .wishbone_port_dat_w(wishbone_port_dat_w),
    .wishbone_port_dat_r(wishbone_port_dat_r),
    .wishbone_port_sel  (wishbone_port_sel),
    .wishbone_port_cyc  (wishbone_port_cyc),
    .wishbone_port_stb  (wishbone_port_stb),
    .wishbone_port_we   (wishbone_port_we),
    .wishbone_port_cti  (wishbone_port_cti),
    .wishbone_port_bte  (wishbone_port_bte),
    .wishbone_port_ack  (wishbone_port_ack),
    .wishbone_port_err  (wishbone_port_err),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_first          (cmd_first),
    .cmd_last           (cmd_last),
    .cmd_payload_we     (cmd_payload_we),
    .cmd_payload_addr   (cmd_payload_addr),
    .wdata_valid        (wdata_valid),
    .wdata_ready        (wdata_ready),
    .wdata_first        (wdata_first),
    .wdata_last         (wdata_last),
    .wdata_payload_data (wdata_payload_data),
    .wdata_payload_we   (wdata_payload_we),
    .rdata_valid        (rdata_valid),
    .rdata_ready        (rdata_ready),
    .rdata_first        (rdata_first),
    .rdata_last         (rdata_last),
    .rdata_payload_data (rdata_payload_data)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic        first;
    logic        last;
  } cmd_rec_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  sel;
    logic              first;
    logic              last;
  } wd_rec_t;

  typedef struct {
    logic [31:0]       adr;
    logic              we;
    logic [DATA_W-1:0] dat;
    logic              exp_err;
    logic [31:0]       exp_addr;
  } vec_t;

  cmd_rec_t          cmd_q[$];
  wd_rec_t           wd_q[$];
  int                tests_run = 0;
  int                tests_failed = 0;
  int                ack_cnt = 0;
  int                err_cnt = 0;
  int                cmd_valid_cycles = 0;
  int                neg_cnt = 0;
  int                ack_neg = 0;
  int                rvalid_neg = 0;
  int                rd_delay = 0;
  int                rd_wait = 0;
  logic [DATA_W-1:0] rd_data = '0;

  // Native-side monitor and read-data responder share one process so the
  // cycle stamps they record are ordered consistently.
  initial begin
    forever begin
      @(negedge sys_clk);
      neg_cnt++;
      if (cmd_valid) cmd_valid_cycles++;
      if (cmd_valid && cmd_ready)
        cmd_q.push_back('{cmd_payload_addr, cmd_payload_we, cmd_first, cmd_last});
      if (wdata_valid && wdata_ready)
        wd_q.push_back('{wdata_payload_data, wdata_payload_we, wdata_first, wdata_last});
      if (wishbone_port_ack) begin
        ack_cnt++;
        ack_neg = neg_cnt;
      end
      if (wishbone_port_err) err_cnt++;
      if (rdata_valid) begin
        rdata_valid = 1'b0;
        rd_wait = 0;
      end else if (rdata_ready) begin
        if (rd_wait >= rd_delay) begin
          rdata_valid = 1'b1;
          rdata_payload_data = rd_data;
          rvalid_neg = neg_cnt;
        end else begin
          rd_wait++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one Wishbone beat from posedge+1 and waits for ack or err,
  // returning the number of negedges seen including the response one.
  task automatic applyStimulus(input logic [31:0] adr, input logic we, input logic [DATA_W-1:0] dat,
                               input logic [2:0] cti, input logic [1:0] bte, input bit hold_cyc,
                               output int lat, output bit got_ack, output bit got_err);
    wishbone_port_adr   = adr;
    wishbone_port_we    = we;
    wishbone_port_dat_w = dat;
    wishbone_port_sel   = '1;
    wishbone_port_cti   = cti;
    wishbone_port_bte   = bte;
    wishbone_port_cyc   = 1'b1;
    wishbone_port_stb   = 1'b1;
    lat = 0;
    got_ack = 1'b0;
    got_err = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge sys_clk);
      lat++;
      if (wishbone_port_ack || wishbone_port_err) begin
        got_ack = wishbone_port_ack;
        got_err = wishbone_port_err;
        break;
      end
    end
    if (!got_ack && !got_err) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL beat_timeout: adr 0x%0h got no ack or err, expected a response", adr);
    end
    @(posedge sys_clk);
    #1;
    wishbone_port_cyc = hold_cyc;
    wishbone_port_stb = hold_cyc;
  endtask

  initial begin
    vec_t        vecs[5];
    logic [31:0] wrap_adr[4];
    int          lat, c0, w0, a0, e0, v0;
    bit          ga, ge, found;

    vecs[0] = '{32'h40000000, 1'b1, 64'h1, 1'b0, 32'h0};
    vecs[1] = '{32'h4FFFFFFF, 1'b1, 64'h55AA_0000_1234_00FF, 1'b0, 32'h0FFFFFFF};
    vecs[2] = '{32'h3FFFFFFF, 1'b1, 64'h7, 1'b1, 32'h0};
    vecs[3] = '{32'h50000000, 1'b0, 64'h0, 1'b1, 32'h0};
    vecs[4] = '{32'h40000123, 1'b0, 64'hCAFE_F00D_1234_5678, 1'b0, 32'h123};

    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    checkOutput("reset_ack", wishbone_port_ack, 0);
    checkOutput("reset_err", wishbone_port_err, 0);
    checkOutput("reset_cmd_valid", cmd_valid, 0);
    checkOutput("reset_wdata_valid", wdata_valid, 0);
    checkOutput("reset_rdata_ready", rdata_ready, 0);
    checkOutput("reset_dat_r", wishbone_port_dat_r, 0);
    checkOutput("reset_cmd_addr", cmd_payload_addr, 0);
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      c0 = cmd_q.size();
      w0 = wd_q.size();
      a0 = ack_cnt;
      v0 = cmd_valid_cycles;
      rd_data = vecs[i].dat;
      applyStimulus(vecs[i].adr, vecs[i].we, vecs[i].dat, CTI_CLASSIC, BTE_LINEAR, 1'b0, lat, ga, ge);
      repeat (2) @(posedge sys_clk);
      #1;
      if (vecs[i].exp_err) begin
        checkOutput($sformatf("v%0d_err", i), ge, 1);
        checkOutput($sformatf("v%0d_err_latency", i), lat, 2);
        checkOutput($sformatf("v%0d_no_cmd", i), cmd_valid_cycles - v0, 0);
        checkOutput($sformatf("v%0d_no_ack", i), ack_cnt - a0, 0);
      end else begin
        checkOutput($sformatf("v%0d_ack", i), ga, 1);
        checkOutput($sformatf("v%0d_ack_latency", i), lat, 4);
        checkOutput($sformatf("v%0d_one_ack", i), ack_cnt - a0, 1);
        checkOutput($sformatf("v%0d_cmd_count", i), cmd_q.size() - c0, 1);
        if (cmd_q.size() > c0) begin
          checkOutput($sformatf("v%0d_cmd_addr", i), cmd_q[c0].addr, vecs[i].exp_addr);
          checkOutput($sformatf("v%0d_cmd_we", i), cmd_q[c0].we, vecs[i].we);
          checkOutput($sformatf("v%0d_cmd_first", i), cmd_q[c0].first, 1);
          checkOutput($sformatf("v%0d_cmd_last", i), cmd_q[c0].last, 1);
        end
        if (vecs[i].we) begin
          checkOutput($sformatf("v%0d_wdata_count", i), wd_q.size() - w0, 1);
          if (wd_q.size() > w0) begin
            checkOutput($sformatf("v%0d_wdata", i), wd_q[w0].data, vecs[i].dat);
            checkOutput($sformatf("v%0d_wsel", i), wd_q[w0].sel, 8'hFF);
            checkOutput($sformatf("v%0d_wfirst_last", i), {wd_q[w0].first, wd_q[w0].last}, 2'b11);
          end
        end else begin
          checkOutput($sformatf("v%0d_dat_r", i), wishbone_port_dat_r, vecs[i].dat);
        end
      end
    end

    // Classic read with a slow native read return.
    c0 = cmd_q.size();
    rd_delay = 5;
    rd_data = 64'hDEAD;
    applyStimulus(32'h40000010, 1'b0, '0, CTI_CLASSIC, BTE_LINEAR, 1'b0, lat, ga, ge);
    checkOutput("rd_slow_ack", ga, 1);
    checkOutput("rd_slow_ack_after_valid", ack_neg - rvalid_neg, 1);
    checkOutput("rd_slow_dat_r", wishbone_port_dat_r, 64'hDEAD);
    if (cmd_q.size() > c0) begin
      checkOutput("rd_slow_cmd_addr", cmd_q[c0].addr, 32'h10);
      checkOutput("rd_slow_cmd_we", cmd_q[c0].we, 0);
    end else checkOutput("rd_slow_cmd_count", cmd_q.size() - c0, 1);
    rd_delay = 0;

    // Wrap4 read burst: native addresses 6,7,4,5.
    wrap_adr = '{32'h40000006, 32'h40000007, 32'h40000004, 32'h40000005};
    c0 = cmd_q.size();
    a0 = ack_cnt;
    for (int k = 0; k < 4; k++) begin
      rd_data = 64'h1000 + 64'(k);
      applyStimulus(wrap_adr[k], 1'b0, '0, (k < 3) ? CTI_INCR : CTI_EOB, BTE_WRAP4, k < 3, lat, ga, ge);
      checkOutput($sformatf("wrap_b%0d_dat_r", k), wishbone_port_dat_r, 64'h1000 + 64'(k));
    end
    checkOutput("wrap_ack_count", ack_cnt - a0, 4);
    checkOutput("wrap_cmd_count", cmd_q.size() - c0, 4);
    if (cmd_q.size() >= c0 + 4)
      for (int k = 0; k < 4; k++) begin
        checkOutput($sformatf("wrap_b%0d_addr", k), cmd_q[c0+k].addr, wrap_adr[k] - 32'h40000000);
        checkOutput($sformatf("wrap_b%0d_first_last", k), {cmd_q[c0+k].first, cmd_q[c0+k].last},
                    {k == 0, k == 3});
      end

    // Linear 6-beat write with MAX_BURST=4: cap splits it after beat 3.
    c0 = cmd_q.size();
    w0 = wd_q.size();
    for (int k = 0; k < 6; k++)
      applyStimulus(32'h40000000 + 32'(k), 1'b1, 64'h100 + 64'(k), (k < 5) ? CTI_INCR : CTI_EOB,
                    BTE_LINEAR, k < 5, lat, ga, ge);
    checkOutput("cap_cmd_count", cmd_q.size() - c0, 6);
    if (cmd_q.size() >= c0 + 6 && wd_q.size() >= w0 + 6)
      for (int k = 0; k < 6; k++) begin
        checkOutput($sformatf("cap_b%0d_addr", k), cmd_q[c0+k].addr, 32'(k));
        checkOutput($sformatf("cap_b%0d_first_last", k), {cmd_q[c0+k].first, cmd_q[c0+k].last},
                    {k == 0 || k == 4, k == 3 || k == 5});
        checkOutput($sformatf("cap_b%0d_wdata", k), wd_q[w0+k].data, 64'h100 + 64'(k));
        checkOutput($sformatf("cap_b%0d_wframe", k), {wd_q[w0+k].first, wd_q[w0+k].last},
                    {k == 0 || k == 4, k == 3 || k == 5});
      end

    // Linear burst running off the top of the window errors on beat 1.
    c0 = cmd_q.size();
    e0 = err_cnt;
    applyStimulus(32'h4FFFFFFF, 1'b1, 64'h11, CTI_INCR, BTE_LINEAR, 1'b1, lat, ga, ge);
    checkOutput("top_b0_ack", ga, 1);
    applyStimulus(32'h50000000, 1'b1, 64'h22, CTI_EOB, BTE_LINEAR, 1'b0, lat, ga, ge);
    checkOutput("top_b1_err", ge, 1);
    checkOutput("top_err_count", err_cnt - e0, 1);
    checkOutput("top_cmd_count", cmd_q.size() - c0, 1);

    // Abort during a stalled WDATA beat mid-burst.
    applyStimulus(32'h40000100, 1'b1, 64'hA0, CTI_INCR, BTE_LINEAR, 1'b1, lat, ga, ge);
    checkOutput("abort_b0_ack", ga, 1);
    a0 = ack_cnt;
    w0 = wd_q.size();
    c0 = cmd_q.size();
    wdata_ready = 1'b0;
    wishbone_port_adr = 32'h40000101;
    wishbone_port_dat_w = 64'hA1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (wdata_valid) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("abort_reached_wdata", found, 1);
    @(posedge sys_clk);
    #1;
    wishbone_port_cyc = 1'b0;
    wishbone_port_stb = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1 wdata_ready = 1'b1;
    repeat (6) @(posedge sys_clk);
    #1;
    checkOutput("abort_wdata_done", wd_q.size() - w0, 1);
    if (wd_q.size() > w0) checkOutput("abort_wdata", wd_q[w0].data, 64'hA1);
    if (cmd_q.size() > c0) checkOutput("abort_cmd_first", cmd_q[c0].first, 0);
    checkOutput("abort_no_ack", ack_cnt - a0, 0);
    c0 = cmd_q.size();
    applyStimulus(32'h40000200, 1'b1, 64'hB0, CTI_CLASSIC, BTE_LINEAR, 1'b0, lat, ga, ge);
    if (cmd_q.size() > c0) begin
      checkOutput("post_abort_addr", cmd_q[c0].addr, 32'h200);
      checkOutput("post_abort_first", cmd_q[c0].first, 1);
    end else checkOutput("post_abort_cmd_count", cmd_q.size() - c0, 1);

    // Reset while stuck in CMD abandons the beat silently and clears dat_r.
    a0 = ack_cnt;
    e0 = err_cnt;
    c0 = cmd_q.size();
    cmd_ready = 1'b0;
    wishbone_port_adr = 32'h40000300;
    wishbone_port_cti = CTI_CLASSIC;
    wishbone_port_cyc = 1'b1;
    wishbone_port_stb = 1'b1;
    repeat (3) @(negedge sys_clk);
    checkOutput("midrst_in_cmd", cmd_valid, 1);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    wishbone_port_cyc = 1'b0;
    wishbone_port_stb = 1'b0;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    cmd_ready = 1'b1;
    repeat (4) @(negedge sys_clk);
    checkOutput("midrst_cmd_valid", cmd_valid, 0);
    checkOutput("midrst_no_ack", ack_cnt - a0, 0);
    checkOutput("midrst_no_err", err_cnt - e0, 0);
    checkOutput("midrst_no_cmd", cmd_q.size() - c0, 0);
    checkOutput("midrst_dat_r", wishbone_port_dat_r, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
